goertzel_multibin_detector: RTL and testbench

//  Block-based, multi-bin Goertzel tone detector; successor to the single-bin free-running filter.

---
 rtl/goertzel_pkg.sv | 32 +++
 rtl/goertzel_bin_core.sv | 85 ++++++++
 rtl/goertzel_multibin_detector.sv | 138 +++++++++++++
 tb/tb_goertzel_multibin_detector.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goertzel_pkg.sv
// Shared definitions for the multi-bin Goertzel detector: FSM states,
// output width helper and the saturating clamp used by every bin core.
package goertzel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Width of one squared-magnitude word for a given recurrence width.
  function automatic int pwr_w(input int acc_w);
    return 2 * acc_w + 2;
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/goertzel_bin_core.sv
// One Goertzel bin: q1/q2 state, saturating recurrence, sticky overflow and
// the end-of-block squared-magnitude computation.
module goertzel_bin_core
  import goertzel_pkg::*;
#(
  parameter int IN_W      = 14,
  parameter int ACC_W     = 24,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 14,
  localparam int PWR_W    = pwr_w(ACC_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     step_i,
  input  logic                     fin_i,
  input  logic signed [IN_W-1:0]   x_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic [PWR_W-1:0]         power_o,
  output logic                     ovf_o
);

  localparam int PROD_W = ACC_W + COEF_W;
  localparam int PF_W   = COEF_W + 2 * ACC_W + 1;
  localparam logic signed [PF_W-1:0] P_MAX = {{(PF_W-PWR_W){1'b0}}, {PWR_W{1'b1}}};

  logic signed [ACC_W-1:0]  q1_q;
  logic signed [ACC_W-1:0]  q2_q;
  logic signed [ACC_W-1:0]  q1_d;
  logic signed [ACC_W-1:0]  q1_cur;
  logic signed [ACC_W-1:0]  q2_cur;
  logic signed [PROD_W-1:0] prod;
  logic signed [63:0]       s_full;
  logic signed [63:0]       s_sat;
  logic                     clip;
  logic                     ovf_acc_q;
  logic signed [PF_W-1:0]   p_full;
  logic [PWR_W-1:0]         p_clamped;

  // Recurrence step; the first sample of a block sees q1=q2=0 so stale state never leaks in.
  always_comb begin
    q1_cur = start_i ? {ACC_W{1'b0}} : q1_q;
    q2_cur = start_i ? {ACC_W{1'b0}} : q2_q;
    prod   = PROD_W'(coef_i) * PROD_W'(q1_cur);
    s_full = 64'(x_i) + 64'(prod >>> COEF_FRAC) - 64'(q2_cur);
    s_sat  = sat(s_full, ACC_W);
    clip   = (s_sat != s_full);
    q1_d   = s_sat[ACC_W-1:0];
  end

  // Block power from the final state; negative results (coefficient rounding) clamp to zero.
  always_comb begin
    p_full = PF_W'(q1_q) * PF_W'(q1_q) + PF_W'(q2_q) * PF_W'(q2_q)
           - ((PF_W'(coef_i) * PF_W'(q1_q) * PF_W'(q2_q)) >>> COEF_FRAC);
    if (p_full[PF_W-1]) begin
      p_clamped = {PWR_W{1'b0}};
    end else if (p_full > P_MAX) begin
      p_clamped = {PWR_W{1'b1}};
    end else begin
      p_clamped = p_full[PWR_W-1:0];
    end
  end

  // State update per accepted sample, result capture at the end of the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_q      <= {ACC_W{1'b0}};
      q2_q      <= {ACC_W{1'b0}};
      ovf_acc_q <= 1'b0;
      power_o   <= {PWR_W{1'b0}};
      ovf_o     <= 1'b0;
    end else begin
      if (step_i) begin
        q1_q      <= q1_d;
        q2_q      <= q1_cur;
        ovf_acc_q <= clip | (ovf_acc_q & ~start_i);
      end
      if (fin_i) begin
        power_o <= p_clamped;
        ovf_o   <= ovf_acc_q;
      end
    end
  end

endmodule

// File: rtl/goertzel_multibin_detector.sv
// Block-based multi-bin Goertzel detector: sequencing FSM, sample counter,
// per-block latches of coefficients and length, and the two handshakes.
module goertzel_multibin_detector
  import goertzel_pkg::*;
#(
  parameter int IN_W      = 14,
  parameter int ACC_W     = 24,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 14,
  parameter int NUM_BINS  = 2,
  parameter int LEN_W     = 16,
  localparam int PWR_W    = pwr_w(ACC_W)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_BINS*COEF_W-1:0]   coef,
  input  logic [LEN_W-1:0]             block_len,
  input  logic                         abort,
  output logic [NUM_BINS*PWR_W-1:0]    out_power,
  output logic [NUM_BINS-1:0]          out_ovf,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam logic [LEN_W-1:0] ONE_LEN = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e                       state_q;
  logic [LEN_W-1:0]             count_q;
  logic [LEN_W-1:0]             count_d;
  logic [LEN_W-1:0]             len_q;
  logic [LEN_W-1:0]             len_eff;
  logic [NUM_BINS*COEF_W-1:0]   coef_q;
  logic [NUM_BINS*COEF_W-1:0]   coef_use;
  logic                         in_ready_q;
  logic                         out_valid_q;
  logic                         accept;
  logic                         start;
  logic                         fin;

  // Handshake qualification; an abort in the same cycle drops the offered sample.
  always_comb begin
    accept   = in_valid & in_ready_q & ~abort
             & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
    start    = accept & (state_q == ST_IDLE);
    fin      = (state_q == ST_FINAL) & ~abort;
    len_eff  = (block_len == {LEN_W{1'b0}}) ? ONE_LEN : block_len;
    coef_use = start ? coef : coef_q;
    count_d  = count_q + ONE_LEN;
  end

  // Block sequencing FSM with registered in_ready/out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= {LEN_W{1'b0}};
      len_q       <= ONE_LEN;
      coef_q      <= {(NUM_BINS*COEF_W){1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (start) begin
            coef_q  <= coef;
            len_q   <= len_eff;
            count_q <= ONE_LEN;
            if (len_eff == ONE_LEN) begin
              state_q    <= ST_FINAL;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (abort) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
          end else if (accept) begin
            count_q <= count_d;
            if (count_d == len_q) begin
              state_q    <= ST_FINAL;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_FINAL: begin
          if (abort) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
          end else begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
    goertzel_bin_core #(
      .IN_W      (IN_W),
      .ACC_W     (ACC_W),
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC)
    ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .step_i  (accept),
      .fin_i   (fin),
      .x_i     (in_data),
      .coef_i  (coef_use[b*COEF_W +: COEF_W]),
      .power_o (out_power[b*PWR_W +: PWR_W]),
      .ovf_o   (out_ovf[b])
    );
  end

endmodule

// File: tb/tb_goertzel_multibin_detector.sv
// Self-checking bench for goertzel_multibin_detector: directed scenarios plus
// randomized blocks, all compared against a plain-arithmetic Goertzel model.
module tb_goertzel_multibin_detector;

  localparam int PWR_W = 50;

  typedef logic signed [13:0] samp_t;
  typedef samp_t samp_q_t[$];

  logic         clk;
  logic         rst_n;
  logic [13:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [35:0]  coef;
  logic [15:0]  block_len;
  logic         abort;
  logic [99:0]  out_power;
  logic [1:0]   out_ovf;
  logic         out_valid;
  logic         out_ready;

  int cmp_cnt = 0;
  int err_cnt = 0;

  goertzel_multibin_detector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef      (coef),
    .block_len (block_len),
    .abort     (abort),
    .out_power (out_power),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: straight Goertzel over the whole block with floor shifts and clamping.
  function automatic void model(input samp_q_t xs, input longint c, output longint p, output bit ovf);
    longint q1;
    longint q2;
    longint s;
    q1 = 64'sd0;
    q2 = 64'sd0;
    ovf = 1'b0;
    foreach (xs[i]) begin
      s = longint'(xs[i]) + ((c * q1) >>> 14) - q2;
      if (s > 64'sd8388607) begin
        s = 64'sd8388607;
        ovf = 1'b1;
      end else if (s < -64'sd8388608) begin
        s = -64'sd8388608;
        ovf = 1'b1;
      end
      q2 = q1;
      q1 = s;
    end
    p = q1 * q1 + q2 * q2 - ((c * q1 * q2) >>> 14);
    if (p < 64'sd0) p = 64'sd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coefs(input longint a, input longint b);
    coef = {18'(b), 18'(a)};
  endtask

  // Offer one sample (optionally after random idle cycles) and hold it until accepted.
  task automatic feed(input samp_t x, input bit gaps, output bit ok);
    int g;
    ok = 1'b1;
    g = 0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 0 && g < 8) begin
        in_valid = 1'b0;
        tick();
        g++;
      end
    end
    in_data = x;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin
      tick();
      g++;
    end
    if (!in_ready) ok = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_block(input samp_q_t xs, input bit gaps, input bit scramble, output bit ok);
    bit fok;
    ok = 1'b1;
    foreach (xs[i]) begin
      feed(xs[i], gaps, fok);
      ok &= fok;
      if (scramble && i == 0) begin
        coef = {$urandom(), $urandom()};
        block_len = 16'($urandom_range(40, 0));
      end
    end
  endtask

  task automatic wait_out(output bit got);
    int g;
    g = 0;
    while (!out_valid && g < 10) begin
      tick();
      g++;
    end
    got = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 14'd0; abort = 1'b0; out_ready = 1'b1;
    block_len = 16'd8; set_coefs(64'sd32768, 64'sd23170);
    tick();
    tick();
    cmp_cnt++;
    if (out_valid !== 1'b0 || out_power !== 100'd0 || out_ovf !== 2'b00 || in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: valid=%b power=%h ovf=%b in_ready=%b, required all 0",
               out_valid, out_power, out_ovf, in_ready);
    end
    rst_n = 1'b1;
    tick();
    cmp_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_dc();
    samp_q_t xs;
    longint p0, p1;
    bit o0, o1, ok;
    repeat (8) xs.push_back(14'sd100);
    set_coefs(64'sd32768, 64'sd23170); block_len = 16'd8; out_ready = 1'b1;
    model(xs, 64'sd32768, p0, o0);
    model(xs, 64'sd23170, p1, o1);
    send_block(xs, 1'b0, 1'b0, ok);
    cmp_cnt++;
    if (!ok || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL dc_latency_early: ok=%b out_valid=%b, required ok=1 out_valid=0", ok, out_valid);
    end
    tick();
    cmp_cnt++;
    if (out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL dc_latency: out_valid=%b, required 1", out_valid);
    end
    cmp_cnt++;
    if (out_power[49:0] !== 50'd640000 || out_power[49:0] !== 50'(p0)) begin
      err_cnt++;
      $display("FAIL dc_bin0: got %0d, required 640000 (model %0d)", out_power[49:0], p0);
    end
    cmp_cnt++;
    if (out_power[99:50] !== 50'(p1) || out_power[99:50] > 50'd640 || out_ovf !== 2'b00) begin
      err_cnt++;
      $display("FAIL dc_bin1: got %0d ovf=%b, required %0d (<=640) ovf=00", out_power[99:50], out_ovf, p1);
    end
    tick();
    cmp_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL dc_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_tone();
    samp_q_t xs;
    longint p0, p1;
    bit o0, o1, ok, got;
    xs = '{14'sd1000, 14'sd707, 14'sd0, -14'sd707, -14'sd1000, -14'sd707, 14'sd0, 14'sd707};
    set_coefs(64'sd32768, 64'sd23170); block_len = 16'd8; out_ready = 1'b1;
    model(xs, 64'sd32768, p0, o0);
    model(xs, 64'sd23170, p1, o1);
    send_block(xs, 1'b1, 1'b0, ok);
    wait_out(got);
    cmp_cnt++;
    if (!ok || !got || out_power[99:50] !== 50'(p1)
        || out_power[99:50] < 50'd15920000 || out_power[99:50] > 50'd16080000) begin
      err_cnt++;
      $display("FAIL tone_bin1: got %0d, required %0d within 16e6 +/-0.5%%", out_power[99:50], p1);
    end
    cmp_cnt++;
    if (out_power[49:0] !== 50'(p0) || out_power[49:0] > 50'd160000) begin
      err_cnt++;
      $display("FAIL tone_bin0: got %0d, required %0d (<=160000)", out_power[49:0], p0);
    end
    tick();
  endtask

  task automatic test_backpressure();
    samp_q_t xs;
    bit ok, got, bad;
    repeat (8) xs.push_back(14'sd100);
    block_len = 16'd8; out_ready = 1'b0;
    send_block(xs, 1'b1, 1'b0, ok);
    wait_out(got);
    bad = !ok || !got;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_power[49:0] !== 50'd640000) bad = 1'b1;
      tick();
    end
    cmp_cnt++;
    if (bad) begin
      err_cnt++;
      $display("FAIL bp_hold: valid=%b in_ready=%b bin0=%0d, required 1/0/640000 held",
               out_valid, in_ready, out_power[49:0]);
    end
    out_ready = 1'b1;
    tick();
    cmp_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    send_block(xs, 1'b1, 1'b0, ok);
    wait_out(got);
    cmp_cnt++;
    if (!ok || !got || out_power[49:0] !== 50'd640000) begin
      err_cnt++;
      $display("FAIL bp_next_block: got %0d, required 640000", out_power[49:0]);
    end
    tick();
  endtask

  task automatic test_abort();
    samp_q_t xs, half;
    bit ok, got, seen;
    repeat (8) xs.push_back(14'sd100);
    repeat (4) half.push_back(14'sd3000);
    block_len = 16'd8; out_ready = 1'b1;
    send_block(half, 1'b0, 1'b0, ok);
    in_data = 14'sd5000; in_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= out_valid;
      tick();
    end
    cmp_cnt++;
    if (seen || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL abort_no_output: seen_valid=%b in_ready=%b, required 0/1", seen, in_ready);
    end
    send_block(xs, 1'b0, 1'b0, ok);
    wait_out(got);
    cmp_cnt++;
    if (!ok || !got || out_power[49:0] !== 50'd640000) begin
      err_cnt++;
      $display("FAIL abort_next_block: got %0d, required 640000", out_power[49:0]);
    end
    tick();
  endtask

  task automatic test_saturation();
    samp_q_t xs;
    longint p0, p1;
    bit o0, o1, ok, got;
    repeat (65535) xs.push_back(14'sd8191);
    set_coefs(64'sd32768, 64'sd23170); block_len = 16'd65535; out_ready = 1'b1;
    model(xs, 64'sd32768, p0, o0);
    model(xs, 64'sd23170, p1, o1);
    send_block(xs, 1'b0, 1'b0, ok);
    wait_out(got);
    cmp_cnt++;
    if (!ok || !got || out_ovf[0] !== 1'b1 || out_ovf[1] !== o1) begin
      err_cnt++;
      $display("FAIL sat_ovf: got %b, required {%b,1}", out_ovf, o1);
    end
    cmp_cnt++;
    if (out_power[49:0] !== 50'(p0) || out_power[99:50] !== 50'(p1)) begin
      err_cnt++;
      $display("FAIL sat_power: got %0d/%0d, required %0d/%0d", out_power[49:0], out_power[99:50], p0, p1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    samp_q_t xs, part;
    samp_t x;
    bit ok, got;
    repeat (8) xs.push_back(14'sd100);
    repeat (3) part.push_back(14'sd100);
    block_len = 16'd8; out_ready = 1'b0;
    send_block(part, 1'b0, 1'b0, ok);
    rst_n = 1'b0;
    tick();
    cmp_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_ovf !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_accum: valid=%b in_ready=%b ovf=%b, required 0", out_valid, in_ready, out_ovf);
    end
    rst_n = 1'b1;
    tick();
    send_block(xs, 1'b0, 1'b0, ok);
    wait_out(got);
    rst_n = 1'b0;
    tick();
    cmp_cnt++;
    if (!ok || !got || out_valid !== 1'b0 || out_power !== 100'd0 || in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_out: got=%b valid=%b power=%h in_ready=%b, required 1/0/0/0",
               got, out_valid, out_power, in_ready);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    x = samp_t'($urandom_range(16383, 0));
    block_len = 16'd0;
    part.delete();
    part.push_back(x);
    send_block(part, 1'b0, 1'b0, ok);
    cmp_cnt++;
    if (!ok || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL n0_latency_early: ok=%b out_valid=%b, required 1/0", ok, out_valid);
    end
    tick();
    cmp_cnt++;
    if (out_valid !== 1'b1 || out_power[49:0] !== 50'(longint'(x) * longint'(x))) begin
      err_cnt++;
      $display("FAIL n0_power: valid=%b got %0d, required 1 and %0d", out_valid, out_power[49:0],
               longint'(x) * longint'(x));
    end
    tick();
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      samp_q_t xs;
      longint c0, c1, p0, p1;
      bit o0, o1, ok, got;
      int n;
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) xs.push_back(samp_t'($urandom_range(16383, 0)));
      c0 = longint'($urandom_range(65535, 0)) - 64'sd32768;
      c1 = longint'($urandom_range(65535, 0)) - 64'sd32768;
      model(xs, c0, p0, o0);
      model(xs, c1, p1, o1);
      set_coefs(c0, c1); block_len = 16'(n); out_ready = 1'b0;
      send_block(xs, 1'b1, 1'b1, ok);
      wait_out(got);
      repeat ($urandom_range(3, 0)) tick();
      cmp_cnt++;
      if (!ok || !got || out_power[49:0] !== 50'(p0) || out_power[99:50] !== 50'(p1)
          || out_ovf !== {o1, o0}) begin
        err_cnt++;
        $display("FAIL random_block%0d: n=%0d got %0d/%0d ovf=%b, required %0d/%0d ovf=%b",
                 b, n, out_power[49:0], out_power[99:50], out_ovf, p0, p1, {o1, o0});
      end
      out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_tone();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
